// File: rtl/hilo_muldiv_sequencer.sv
// Hi/Lo owner: iterative shift-add MULT/MULTU and restoring DIV/DIVU plus MTHI/MTLO writes.
// Optional macro HILO_FAST_MUL_EN swaps the multiply sequence for a single-cycle multiplier.
module hilo_muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             read_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, SIGN} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;      // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opnd;     // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]   a_raw;
  logic               is_div, neg_p, neg_r, dbz;

  logic               op_signed, is_mul_op, is_div_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_signed = ~op[0];
  assign is_mul_op = (op[2:1] == 2'b00);
  assign is_div_op = (op[2:1] == 2'b01);
  assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;

  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};

  // neg_p is the product sign for multiply and the quotient sign for divide.
  assign prod_fix  = neg_p ? -acc : acc;
  assign quo_fix   = neg_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (start && is_mul_op) begin
`ifdef HILO_FAST_MUL_EN
          state_nxt = SIGN;
`else
          state_nxt = MUL;
`endif
        end else if (start && is_div_op) begin
          state_nxt = DIV;
        end
      end
      MUL:     if (cnt == LAST) state_nxt = SIGN;
      DIV:     if (cnt == LAST) state_nxt = SIGN;
      SIGN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    stall = busy & (start | read_req);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      a_raw       <= '0;
      is_div      <= 1'b0;
      neg_p       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cnt <= '0;
          if (is_mul_op) begin
            opnd   <= a_mag;
            neg_p  <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= 1'b0;
            is_div <= 1'b0;
            dbz    <= 1'b0;
`ifdef HILO_FAST_MUL_EN
            acc    <= {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`else
            acc    <= {{WIDTH{1'b0}}, b_mag};
`endif
          end else if (is_div_op) begin
            opnd   <= b_mag;
            acc    <= {{WIDTH{1'b0}}, a_mag};
            neg_p  <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= op_signed & a[WIDTH-1];
            is_div <= 1'b1;
            dbz    <= (b == '0);
            a_raw  <= a;
          end else if (op == 3'b100) begin
            hi <= a;
          end else if (op == 3'b101) begin
            lo <= a;
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
        DIV: begin
          if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else                  acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
        end
        SIGN: begin
          done <= 1'b1;
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (dbz) begin
            // Divide-by-zero still runs the full sequence so latency stays fixed.
            hi          <= a_raw;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Bench for hilo_muldiv_sequencer: expected results queued at issue, compared on each Done pulse.
module tb_hilo_muldiv_sequencer;
  localparam int W   = 32;
  localparam int LAT = W + 1;
`ifdef HILO_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk, rst, start, read_req;
  logic [2:0]   op;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, stall, done, div_by_zero;

  typedef struct {
    int           id;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           issue;
    int           lat;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   nid = 0;
  int   scnt;
  bit   prev_done = 1'b0;

  hilo_muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .read_req(read_req),
    .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] mh, output logic [W-1:0] ml, output logic mz);
    longint p;
    mz = 1'b0;
    case (o)
      3'b000: p = longint'(int'(x)) * longint'(int'(y));
      3'b001: p = longint'({32'b0, x}) * longint'({32'b0, y});
      default: p = 0;
    endcase
    mh = p[63:32];
    ml = p[31:0];
    if (o[1]) begin
      if (y == 0) begin
        mh = x; ml = '1; mz = 1'b1;
      end else if (o[0]) begin
        ml = x / y; mh = x % y;
      end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
        ml = 32'h80000000; mh = 0;
      end else begin
        ml = int'(x) / int'(y); mh = int'(x) % int'(y);
      end
    end
  endfunction

  task automatic push_exp(input logic [2:0] o, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input logic ez);
    exp_t e;
    e.id = nid; e.hi = eh; e.lo = el; e.dbz = ez; e.issue = cyc + 1;
    e.lat = (FAST && !o[1]) ? 1 : LAT;
    nid++;
    sb.push_back(e);
  endtask

  // Called just after a clock edge with the DUT idle; returns just after the accepting edge.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input bit push, input logic [W-1:0] eh, input logic [W-1:0] el,
                       input logic ez);
    start = 1'b1; op = o; a = xa; b = xb;
    if (push) push_exp(o, eh, el, ez);
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("idle_timeout", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_done) chk("pulse_width", {done, div_by_zero}, 2'b00);
      if (!done) begin
        chk("dbz_without_done", div_by_zero, 1'b0);
      end else if (sb.size() == 0) begin
        chk("unexpected_done", done, 1'b0);
      end else begin
        cur = sb.pop_front();
        chk($sformatf("op%0d_hi", cur.id), hi, cur.hi);
        chk($sformatf("op%0d_lo", cur.id), lo, cur.lo);
        chk($sformatf("op%0d_dbz", cur.id), div_by_zero, cur.dbz);
        chk($sformatf("op%0d_latency", cur.id), cyc - cur.issue, cur.lat);
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog sb_left=%0d", sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra, rb, mh, ml;
    logic         mz;
    rst = 1'b1; start = 1'b1; read_req = 1'b1; op = 3'b011; a = 32'd9; b = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_stall", stall, 0);
    start = 1'b0; read_req = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;

    do_op(3'b001, 32'hFFFFFFFF, 32'h2, 1, 32'h1, 32'hFFFFFFFE, 0);
    wait_idle();
    do_op(3'b000, 32'hFFFFFFFD, 32'h7, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    wait_idle();
    do_op(3'b010, 32'hFFFFFFF9, 32'h2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    wait_idle();
    do_op(3'b011, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0);
    wait_idle();
    do_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 32'h80000000, 0);
    wait_idle();
    do_op(3'b010, 32'd5, 32'd0, 1, 32'd5, 32'hFFFFFFFF, 1);
    wait_idle();
    do_op(3'b011, 32'h80000001, 32'd0, 1, 32'h80000001, 32'hFFFFFFFF, 1);
    wait_idle();

    // Second op and MFHI/MFLO held from the third cycle of a DIV.
    do_op(3'b010, 32'hFFFFFFF9, 32'h2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7; read_req = 1'b1;
    scnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) break;
      scnt++;
      if (i == 10) begin
        chk("hold_hi", hi, 32'h80000001);
        chk("hold_lo", lo, 32'hFFFFFFFF);
      end
    end
    chk("stall_cycles", scnt, W - 1);
    chk("release_done", done, 1);
    chk("release_read_hi", hi, 32'hFFFFFFFF);
    chk("release_read_lo", lo, 32'hFFFFFFFD);
    push_exp(3'b011, 32'd2, 32'd14, 0);
    @(posedge clk); #1;
    start = 1'b0; read_req = 1'b0;
    chk("second_accepted", busy, 1);
    wait_idle();

    do_op(3'b100, 32'h12345678, 32'd0, 0, 0, 0, 0);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_lo_kept", lo, 32'd14);
    chk("mthi_busy", busy, 0);
    do_op(3'b101, 32'hCAFEF00D, 32'd0, 0, 0, 0, 0);
    chk("mtlo_lo", lo, 32'hCAFEF00D);
    chk("mtlo_hi_kept", hi, 32'h12345678);
    do_op(3'b110, 32'h0BADBEEF, 32'd1, 0, 0, 0, 0);
    chk("nop_hi", hi, 32'h12345678);
    chk("nop_lo", lo, 32'hCAFEF00D);
    chk("nop_busy", busy, 0);

    for (int i = 0; i < 12; i++) begin
      rop = 3'(i % 4);
      ra  = $urandom;
      rb  = (i % 3 == 0) ? W'($urandom_range(0, 9)) : W'($urandom);
      model(rop, ra, rb, mh, ml, mz);
      do_op(rop, ra, rb, 1, mh, ml, mz);
      wait_idle();
    end

    // Asynchronous reset in the middle of a DIVU must abort with no Done.
    do_op(3'b100, 32'h0BADF00D, 32'd0, 0, 0, 0, 0);
    do_op(3'b101, 32'h600DCAFE, 32'd0, 0, 0, 0, 0);
    do_op(3'b011, 32'd1000, 32'd3, 0, 0, 0, 0);
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("post_abort_busy", busy, 0);
    do_op(3'b001, 32'd3, 32'd4, 1, 32'd0, 32'd12, 0);
    wait_idle();

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
